// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph patterns, segment bit positions and capture FSM states shared by the 7-segment scan capture
package seg7_pkg;
   // Segment bus bit positions (active-low bus, a..g then dp)
   localparam int SEG_A  = 7;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;
   // abcdefg patterns, active-low, for hex digits 0..F
   localparam logic [6:0] GLYPH_0 = 7'b0000001;
   localparam logic [6:0] GLYPH_1 = 7'b1001111;
   localparam logic [6:0] GLYPH_2 = 7'b0010010;
   localparam logic [6:0] GLYPH_3 = 7'b0000110;
   localparam logic [6:0] GLYPH_4 = 7'b1001100;
   localparam logic [6:0] GLYPH_5 = 7'b0100100;
   localparam logic [6:0] GLYPH_6 = 7'b0100000;
   localparam logic [6:0] GLYPH_7 = 7'b0001111;
   localparam logic [6:0] GLYPH_8 = 7'b0000000;
   localparam logic [6:0] GLYPH_9 = 7'b0000100;
   localparam logic [6:0] GLYPH_A = 7'b0001000;
   localparam logic [6:0] GLYPH_B = 7'b1100000;
   localparam logic [6:0] GLYPH_C = 7'b0110001;
   localparam logic [6:0] GLYPH_D = 7'b1000010;
   localparam logic [6:0] GLYPH_E = 7'b0110000;
   localparam logic [6:0] GLYPH_F = 7'b0111000;
   localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
   // Packed table indexed by nibble value
   localparam logic [15:0][6:0] GLYPHS = {GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
                                          GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0};
   typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;
endpackage

// File: rtl/seg7_glyph_encoder.sv
// seg7_glyph_encoder: decodes an active-low abcdefg pattern into a hex nibble
//   pat   - 7-bit segment pattern (bit6=a .. bit0=g)
//   nib   - decoded nibble (0 when not a legal glyph)
//   legal - pattern matches one of the 16 hex glyphs
//   blank - all segments dark
module seg7_glyph_encoder
   import seg7_pkg::*;
(
   input  logic [6:0] pat,
   output logic [3:0] nib,
   output logic       legal,
   output logic       blank
);
   always_comb begin
      nib   = '0;
      legal = 1'b0;
      for (int k = 0; k < 16; k++) begin
         if (pat == GLYPHS[k]) begin
            nib   = 4'(k);
            legal = 1'b1;
         end
      end
   end
   assign blank = pat == GLYPH_BLANK;
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: captures per-digit hex values from a multiplexed active-low 7-segment scan bus
//   clk, rst_n - clock and asynchronous active-low reset
//   an         - active-low anode enables, one low bit selects a digit
//   seg        - active-low segments, bit7=a .. bit1=g, bit0=dp
//   digits     - captured nibble per digit, digit i at [4i+3:4i]
//   dp         - captured decimal point per digit (1 = lit)
//   valid      - last commit for the digit was a legal hex glyph
//   upd        - one-cycle pulse per commit, upd_idx names the digit
//   err        - one-cycle pulse on illegal glyph commit or new multi-anode run
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [7:0]              seg,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   dp,
   output logic [NUM_DIGITS-1:0]   valid,
   output logic                    upd,
   output logic [3:0]              upd_idx,
   output logic                    err
);
   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
   logic [1:0]            rst_sync;
   logic                  rst_sn;
   logic [NUM_DIGITS-1:0] an_s, an_p;
   logic [7:0]            seg_s, seg_p;
   logic [4:0]            lows, lows_p;
   logic [3:0]            idx;
   logic                  onehot, multi, multi_p, same, commit;
   logic [7:0]            cnt, cnt_n;
   state_t                state, state_n;
   logic [3:0]            nib;
   logic                  legal, blank;
   // Assert asynchronously, release two edges after rst_n rises
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= '0;
      else rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_sn = rst_sync[1];
   // Current and previous samples; all-ones means no anode and blank segments
   always_ff @(posedge clk or negedge rst_sn) begin
      if (!rst_sn) begin
         an_s  <= '1;
         seg_s <= '1;
         an_p  <= '1;
         seg_p <= '1;
      end else begin
         an_s  <= an;
         seg_s <= seg;
         an_p  <= an_s;
         seg_p <= seg_s;
      end
   end
   always_comb begin
      lows   = '0;
      lows_p = '0;
      idx    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!an_s[i]) begin
            lows = lows + 5'd1;
            idx  = 4'(i);
         end
         if (!an_p[i]) lows_p = lows_p + 5'd1;
      end
   end
   assign onehot  = lows == 5'd1;
   assign multi   = lows > 5'd1;
   assign multi_p = lows_p > 5'd1;
   assign same    = {an_s, seg_s} == {an_p, seg_p};
   seg7_glyph_encoder u_enc (
      .pat   (seg_s[SEG_A:SEG_G]),
      .nib   (nib),
      .legal (legal),
      .blank (blank)
   );
   always_ff @(posedge clk or negedge rst_sn) begin
      if (!rst_sn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
   // The commit fires on the edge where the counter reaches STABLE, so the
   // output register and the move to HELD happen together.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      commit  = 1'b0;
      if (!onehot) begin
         state_n = IDLE;
         cnt_n   = '0;
      end else if (!(state == HELD && same)) begin
         cnt_n   = (state == TRACK && same) ? ((cnt >= STABLE) ? STABLE : cnt + 8'd1) : 8'd1;
         commit  = cnt_n == STABLE;
         state_n = commit ? HELD : TRACK;
      end
   end
   always_ff @(posedge clk or negedge rst_sn) begin
      if (!rst_sn) begin
         digits  <= '0;
         dp      <= '0;
         valid   <= '0;
         upd     <= 1'b0;
         upd_idx <= '0;
         err     <= 1'b0;
      end else begin
         upd <= commit;
         err <= (commit && !legal && !blank) || (multi && !multi_p);
         if (commit) upd_idx <= idx;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (commit && !an_s[i]) begin
               dp[i]    <= ~seg_s[SEG_DP];
               valid[i] <= legal;
               if (legal) digits[4*i +: 4] <= nib;
            end
         end
      end
   end
endmodule
